// File: rtl/pcileech_tlps128_cfg_cpl_builder.sv
// Config-access completion builder: buffers controller results
// and emits single-beat 128-bit Cpl/CplD TLPs.
module pcileech_tlps128_cfg_cpl_builder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_pcie,
  input  logic             rst_n,
  input  logic [15:0]      pcie_id,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_tlpwr,
  input  logic [7:0]       req_tag,
  input  logic [15:0]      req_reqid,
  input  logic [31:0]      req_data,
  input  logic [2:0]       req_status,
  output logic [127:0]     tx_tdata,
  output logic [3:0]       tx_tkeep,
  output logic             tx_tlast,
  output logic             tx_tuser,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 60;
  localparam logic [AW:0] ONE = 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [AW:0]   wptr_n, rptr_n;
  logic          push, pop, drop;
  logic          empty, full_n;
  logic [EW-1:0] din, head;

  logic          h_wr;
  logic [7:0]    h_tag;
  logic [15:0]   h_rid;
  logic [31:0]   h_data;
  logic [2:0]    h_st;
  logic [2:0]    st;
  logic          cpld;
  logic [127:0]  hdr;
  logic [3:0]    keep;

  assign push  = req_valid && req_ready;
  assign drop  = req_valid && !req_ready;
  assign empty = (wptr == rptr);
  assign pop   = (!tx_tvalid || tx_tready) && !empty;

  assign wptr_n = push ? wptr + ONE : wptr;
  assign rptr_n = pop  ? rptr + ONE : rptr;
  assign full_n = (wptr_n[AW] != rptr_n[AW]) &&
                  (wptr_n[AW-1:0] == rptr_n[AW-1:0]);

  assign din  = {req_tlpwr, req_tag, req_reqid,
                 req_data, req_status};
  assign head = mem[rptr[AW-1:0]];

  assign h_wr   = head[59];
  assign h_tag  = head[58:51];
  assign h_rid  = head[50:35];
  assign h_data = head[34:3];
  assign h_st   = head[2:0];

  // Unknown status codes are reported as UR
  always_comb begin
    st = 3'b001;
    unique case (1'b1)
      (h_st == 3'b000): st = 3'b000;
      (h_st == 3'b100): st = 3'b100;
      default:          st = 3'b001;
    endcase
  end

  assign cpld = !h_wr && (h_st == 3'b000);
  assign keep = cpld ? 4'hF : 4'h7;
  assign hdr  = {
    cpld ? h_data : 32'h0,
    h_rid, h_tag, 1'b0, 7'h00,
    pcie_id, st, 1'b0, 12'd4,
    cpld ? 32'h4A000001 : 32'h0A000000
  };

  // FIFO storage; contents are don't-care until pushed
  always_ff @(posedge clk_pcie) begin
    if (push)
      mem[wptr[AW-1:0]] <= din;
  end

  // FIFO pointers and registered ready
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      req_ready <= 1'b1;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      req_ready <= !full_n;
    end
  end

  // Output skid register holds the TLP under backpressure
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
      tx_tkeep  <= '0;
    end else if (pop) begin
      tx_tvalid <= 1'b1;
      tx_tdata  <= hdr;
      tx_tkeep  <= keep;
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
      tx_tkeep  <= '0;
    end
  end

  assign tx_tlast = tx_tvalid;
  assign tx_tuser = tx_tvalid;

  // Drop and sent accounting
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      sent_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
      if (drop)
        overflow <= 1'b1;
      if (tx_tvalid && tx_tready)
        sent_cnt <= sent_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pcileech_tlps128_cfg_cpl_builder.sv
// Self-checking bench: directed scenarios plus random traffic
// against a queue-based completion model.
module tb_pcileech_tlps128_cfg_cpl_builder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk_pcie = 1'b0;
  logic             rst_n;
  logic [15:0]      pcie_id;
  logic             req_valid;
  logic             req_ready;
  logic             req_tlpwr;
  logic [7:0]       req_tag;
  logic [15:0]      req_reqid;
  logic [31:0]      req_data;
  logic [2:0]       req_status;
  logic [127:0]     tx_tdata;
  logic [3:0]       tx_tkeep;
  logic             tx_tlast;
  logic             tx_tuser;
  logic             tx_tvalid;
  logic             tx_tready;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] sent_cnt;
  logic             overflow;

  pcileech_tlps128_cfg_cpl_builder #(
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_pcie(clk_pcie), .rst_n(rst_n),
    .pcie_id(pcie_id),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tlpwr(req_tlpwr), .req_tag(req_tag),
    .req_reqid(req_reqid), .req_data(req_data),
    .req_status(req_status),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep),
    .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .drop_cnt(drop_cnt), .sent_cnt(sent_cnt),
    .overflow(overflow)
  );

  always #5 clk_pcie = ~clk_pcie;

  typedef struct {
    logic        wr;
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [31:0] data;
    logic [2:0]  st;
  } ent_t;

  ent_t         q[$];
  bit           m_out_v;
  logic [127:0] m_out_d;
  logic [3:0]   m_out_k;
  bit           m_ready;
  int           m_drop;
  int           m_sent;
  bit           m_ovf;

  int checks = 0;
  int failures = 0;
  int vcount;
  int sent0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Completion as the PCIe rules define it for one result
  function automatic logic [127:0] mk_tlp(ent_t e,
                                          logic [15:0] id);
    logic [2:0]  s;
    logic [31:0] dw0, dw1, dw2, dw3;
    bit          ok;
    if (e.st == 3'b000 || e.st == 3'b100) s = e.st;
    else s = 3'b001;
    ok  = (e.wr == 1'b0) && (e.st == 3'b000);
    dw0 = ok ? 32'h4A000001 : 32'h0A000000;
    dw1 = {id, s, 1'b0, 12'd4};
    dw2 = {e.rid, e.tag, 8'h00};
    dw3 = ok ? e.data : 32'h0;
    return {dw3, dw2, dw1, dw0};
  endfunction

  function automatic logic [3:0] mk_keep(ent_t e);
    return (!e.wr && e.st == 3'b000) ? 4'hF : 4'h7;
  endfunction

  task automatic model_reset();
    q.delete();
    m_out_v = 0;
    m_out_d = '0;
    m_out_k = '0;
    m_ready = 1;
    m_drop  = 0;
    m_sent  = 0;
    m_ovf   = 0;
  endtask

  task automatic step(input bit v, input bit wr,
                      input logic [7:0] tag,
                      input logic [15:0] rid,
                      input logic [31:0] data,
                      input logic [2:0] st,
                      input bit rdy);
    ent_t e;
    bit   psh;
    req_valid  = v;
    req_tlpwr  = wr;
    req_tag    = tag;
    req_reqid  = rid;
    req_data   = data;
    req_status = st;
    tx_tready  = rdy;
    @(posedge clk_pcie);
    psh = v && m_ready;
    if (v && !m_ready) begin
      m_ovf = 1;
      if (m_drop != 16'hFFFF) m_drop++;
    end
    if (m_out_v && rdy) m_sent = (m_sent + 1) % 65536;
    if ((!m_out_v || rdy) && q.size() > 0) begin
      e = q.pop_front();
      m_out_v = 1;
      m_out_d = mk_tlp(e, pcie_id);
      m_out_k = mk_keep(e);
    end else if (rdy) begin
      m_out_v = 0;
    end
    if (psh) begin
      e.wr = wr; e.tag = tag; e.rid = rid;
      e.data = data; e.st = st;
      q.push_back(e);
    end
    m_ready = (q.size() < DEPTH);
    #1;
    chk("tvalid", 128'(tx_tvalid), 128'(m_out_v));
    chk("req_ready", 128'(req_ready), 128'(m_ready));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    chk("sent_cnt", 128'(sent_cnt), 128'(m_sent));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    if (m_out_v) begin
      chk("tdata", tx_tdata, m_out_d);
      chk("tkeep", 128'(tx_tkeep), 128'(m_out_k));
      chk("tlast", 128'(tx_tlast), 128'(1));
      chk("tuser", 128'(tx_tuser), 128'(1));
    end
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 8'h00, 16'h0, 32'h0, 3'b000, rdy);
  endtask

  initial begin
    rst_n = 0;
    pcie_id = 16'h0300;
    req_valid = 0; req_tlpwr = 0; req_tag = 0;
    req_reqid = 0; req_data = 0; req_status = 0;
    tx_tready = 0;
    model_reset();
    #12;
    chk("rst_tvalid", 128'(tx_tvalid), 128'(0));
    chk("rst_tdata", tx_tdata, 128'(0));
    chk("rst_tkeep", 128'(tx_tkeep), 128'(0));
    chk("rst_tlast", 128'(tx_tlast), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(1));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    @(negedge clk_pcie);
    rst_n = 1;

    // Read hit
    step(1, 0, 8'h5A, 16'h0100, 32'hDEADBEEF, 3'b000, 1);
    idle(1);
    chk("rd_tdata", tx_tdata,
        {32'hDEADBEEF, 32'h01005A00,
         32'h03000004, 32'h4A000001});
    chk("rd_tkeep", 128'(tx_tkeep), 128'(4'hF));
    idle(1);
    chk("rd_sent", 128'(sent_cnt), 128'(1));

    // Write ack
    step(1, 1, 8'h07, 16'h0200, 32'h12345678, 3'b000, 1);
    idle(1);
    chk("wr_dw0", 128'(tx_tdata[31:0]), 128'(32'h0A000000));
    chk("wr_keep", 128'(tx_tkeep), 128'(4'h7));
    chk("wr_st", 128'(tx_tdata[47:45]), 128'(0));
    chk("wr_dw3", 128'(tx_tdata[127:96]), 128'(0));
    idle(1);

    // Reserved status reported as UR
    step(1, 0, 8'h33, 16'h0400, 32'hCAFEF00D, 3'b010, 1);
    idle(1);
    chk("ur_st", 128'(tx_tdata[47:45]), 128'(3'b001));
    chk("ur_keep", 128'(tx_tkeep), 128'(4'h7));
    chk("ur_bc", 128'(tx_tdata[43:32]), 128'(12'd4));
    idle(1);

    // Backpressure: DEPTH+2 pushes, one dropped
    for (int i = 0; i < DEPTH + 2; i++)
      step(1, 0, 8'(8'h10 + i), 16'h0500,
           32'(i), 3'b000, 0);
    idle(0);
    chk("bp_ready", 128'(req_ready), 128'(0));
    chk("bp_drop", 128'(drop_cnt), 128'(1));
    chk("bp_ovf", 128'(overflow), 128'(1));
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("bp_tag", 128'(tx_tdata[79:72]),
          128'(8'h10 + i));
      idle(1);
    end
    chk("bp_empty", 128'(tx_tvalid), 128'(0));
    idle(1);

    // Streaming with wrap
    sent0 = int'(sent_cnt);
    vcount = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 20)
        step(1, 0, 8'(i), 16'h0600, $urandom, 3'b000, 1);
      else
        idle(1);
      if (tx_tvalid) vcount++;
    end
    idle(1);
    chk("st_vcycles", 128'(vcount), 128'(20));
    chk("st_sent", 128'(sent_cnt),
        128'(16'(sent0 + 20)));
    chk("st_drop", 128'(drop_cnt), 128'(1));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0)
        pcie_id = 16'($urandom);
      step($urandom_range(0, 3) != 0,
           1'($urandom), 8'($urandom), 16'($urandom),
           $urandom, 3'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 8; i++) idle(1);

    // Async reset with a held TLP and 3 queued results
    for (int i = 0; i < 4; i++)
      step(1, 0, 8'(8'hA0 + i), 16'h0700,
           32'(i), 3'b000, 0);
    chk("ar_pre_v", 128'(tx_tvalid), 128'(1));
    #2;
    rst_n = 0;
    #1;
    chk("ar_tvalid", 128'(tx_tvalid), 128'(0));
    chk("ar_tdata", tx_tdata, 128'(0));
    chk("ar_tuser", 128'(tx_tuser), 128'(0));
    chk("ar_ready", 128'(req_ready), 128'(1));
    chk("ar_sent", 128'(sent_cnt), 128'(0));
    chk("ar_drop", 128'(drop_cnt), 128'(0));
    chk("ar_ovf", 128'(overflow), 128'(0));
    model_reset();
    @(negedge clk_pcie);
    rst_n = 1;
    for (int i = 0; i < 4; i++) idle(1);
    step(1, 0, 8'hEE, 16'h0800, 32'h0BADF00D, 3'b100, 1);
    idle(1);
    chk("ar_ca_st", 128'(tx_tdata[47:45]), 128'(3'b100));
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pcileech_tlps128_cfg_cpl_builder.md
Name: pcileech_tlps128_cfg_cpl_builder

Overview:
- Downstream stage of the multi-function config-space controller.
- Takes one config-access result per cycle: tag, requester ID, read data, write flag, status. Buffers results in a small FIFO.
- Builds PCIe completion TLPs (CplD for successful reads, Cpl for writes and errors) as single-beat 128-bit AXI-stream packets for the TLP output mux.
- Provides backpressure, drop accounting and a sent-completion counter.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of the drop and sent counters.

Ports:
- clk_pcie  in  1  PCIe core clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- pcie_id  in  16  completer ID {bus, dev, func}; sampled at header build.
- req_valid  in  1  result strobe from the controller.
- req_ready  out  1  FIFO not full.
- req_tlpwr  in  1  1 = the access was CfgWr.
- req_tag  in  8  request tag.
- req_reqid  in  16  requester ID.
- req_data  in  32  config read data.
- req_status  in  3  PCIe completion status: 000 SC, 001 UR, 100 CA; other codes are treated as UR.
- tx_tdata  out  128  completion TLP; DW0 in [31:0], DW3 in [127:96].
- tx_tkeep  out  4  per-DW valid.
- tx_tlast  out  1  always 1 while tx_tvalid is high.
- tx_tuser  out  1  start-of-packet; equal to tx_tvalid.
- tx_tvalid  out  1  packet valid.
- tx_tready  in  1  sink accepts.
- drop_cnt  out  CNT_W  requests lost while full; saturating.
- sent_cnt  out  CNT_W  completions accepted by the sink; wraps.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset (async assert, sync release): FIFO empty; req_ready=1; tx_tvalid=0; tx_tdata=0; tx_tkeep=0; tx_tlast=0; tx_tuser=0; drop_cnt=0; sent_cnt=0; overflow=0.
- Push: req_valid && req_ready. Store {tlpwr, tag, reqid, data, status}.
- req_ready = !full, registered. When full, no push is accepted even if a pop happens in the same cycle; req_ready returns the cycle after the pop.
- Drop: req_valid && !req_ready. The entry is discarded, drop_cnt increments (saturates at all-ones) and overflow is set. No retry path exists.
- Output stage: a one-entry skid register.
  - Loads from the FIFO head when (!tx_tvalid || tx_tready) and the FIFO is not empty.
  - tx_tvalid rises on the clock edge after the push when both the FIFO and the output register were empty. Latency: 1 cycle from push to tx_tvalid.
  - tx_tdata, tx_tkeep and tx_tvalid stay stable while tx_tvalid && !tx_tready.
  - Back-to-back completions are allowed: 1 TLP per cycle at full throughput with tx_tready held high.
- Pop and push in the same cycle with the FIFO non-full: both take effect and occupancy is unchanged. Pointers wrap modulo DEPTH. Full/empty detection uses an extra pointer bit.
- Header selection:
  - CplD when req_tlpwr=0 and status=000: DW0 = 32'h4A000001 (fmt 010, type 01010, length 1); tkeep = 4'b1111; DW3 = req_data.
  - Cpl in all other cases: DW0 = 32'h0A000000 (length 0); tkeep = 4'b0111; DW3 = 0.
  - DW1 = {pcie_id, status[2:0], 1'b0 BCM, byte count}. Byte count is 12'd4 for every completion, including Cpl.
  - DW2 = {req_reqid, req_tag, 1'b0, 7'b0 lower address}.
  - Within each DW, field bit positions match the input TLP layout used elsewhere in the codebase, e.g. fmt/type in DW0[31:24].
- Status normalisation: any code other than 000, 001 or 100 is emitted as 001.
- sent_cnt increments on each tx_tvalid && tx_tready and wraps at 2^CNT_W.
- Reset asserted mid-packet: tx_tvalid drops asynchronously and the FIFO contents are discarded. The sink must tolerate an aborted packet.

Test Plan:
- Read hit: push tlpwr=0, tag=8'h5A, reqid=16'h0100, data=32'hDEADBEEF, status=0, pcie_id=16'h0300, tx_tready=1 -> next cycle tx_tvalid=1, tdata = {32'hDEADBEEF, 32'h01005A00, 32'h03000004, 32'h4A000001}, tkeep=4'hF, tlast=1, sent_cnt=1.
- Write ack: push tlpwr=1, tag=8'h07 -> DW0=32'h0A000000, tkeep=4'h7, DW1[15:13]=000, DW3=0.
- UR: push tlpwr=0, status=3'b010 -> Cpl emitted with DW1[15:13]=001 and tkeep=4'h7.
- Backpressure: tx_tready=0, push DEPTH+2 requests -> the output register plus FIFO hold DEPTH+1 entries, drop_cnt=1, overflow=1, req_ready=0. Release tx_tready -> the held TLPs drain in order, one per cycle, with tags matching push order.
- Streaming: 20 back-to-back pushes with tx_tready=1 -> 20 consecutive tx_tvalid cycles, drop_cnt=0, sent_cnt=20, exercising pointer wrap.
- Async reset: assert rst_n low while tx_tvalid=1 and the FIFO holds 3 entries -> outputs go to their reset values immediately; after release no stale TLP appears.
